// File: rtl/reg_file_hs_if.sv
// Valid/ready write and read channels of the handshaked register file.
// The slave modport is the register file; the master modport drives requests.
interface reg_file_hs_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    wr_valid;
  logic                    wr_ready;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic                    wr_resp_valid;
  logic                    wr_resp_ready;
  logic [1:0]              wr_resp;

  logic                    rd_valid;
  logic                    rd_ready;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    rd_resp_valid;
  logic                    rd_resp_ready;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [1:0]              rd_resp;

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_strb, wr_resp_ready,
    input  rd_valid, rd_addr, rd_resp_ready,
    output wr_ready, wr_resp_valid, wr_resp,
    output rd_ready, rd_resp_valid, rd_data, rd_resp
  );

  modport master (
    output wr_valid, wr_addr, wr_data, wr_strb, wr_resp_ready,
    output rd_valid, rd_addr, rd_resp_ready,
    input  wr_ready, wr_resp_valid, wr_resp,
    input  rd_ready, rd_resp_valid, rd_data, rd_resp
  );
endinterface

// File: rtl/reg_file_hs.sv
// Register file with valid/ready write/read channels, byte strobes and per-register
// RW / RO / W1C access modes; exports stored values and absorbs hardware set / RO inputs.
module reg_file_hs #(
  parameter int unsigned          ADDR_WIDTH = 6,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          REG_NUM    = 8,
  parameter logic [REG_NUM-1:0]   RO_MASK    = '0,
  parameter logic [REG_NUM-1:0]   W1C_MASK   = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  reg_file_hs_if.slave                  bus,
  input  logic [REG_NUM*DATA_WIDTH-1:0] hw_set,
  input  logic [REG_NUM*DATA_WIDTH-1:0] ro_in,
  output logic [REG_NUM*DATA_WIDTH-1:0] reg_q
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned IdxW  = ADDR_WIDTH - 2;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlverr = 2'b10;

  if ((DATA_WIDTH % 8) != 0) begin : g_bad_dw
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (ADDR_WIDTH < 2 + $clog2(REG_NUM)) begin : g_bad_aw
    $error("ADDR_WIDTH too small for REG_NUM");
  end

  logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
  logic [DATA_WIDTH-1:0] regs_d [REG_NUM];

  logic                  wr_resp_valid_q, wr_resp_valid_d;
  logic [1:0]            wr_resp_q, wr_resp_d;
  logic                  rd_resp_valid_q, rd_resp_valid_d;
  logic [1:0]            rd_resp_q, rd_resp_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                  wr_fire, rd_fire;
  logic [IdxW-1:0]       wr_idx, rd_idx;
  logic [REG_NUM-1:0]    wr_hit, rd_hit;
  logic                  wr_err, rd_err, wr_apply;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic [DATA_WIDTH-1:0] rd_sel;

  assign bus.wr_ready      = !wr_resp_valid_q;
  assign bus.rd_ready      = !rd_resp_valid_q;
  assign bus.wr_resp_valid = wr_resp_valid_q;
  assign bus.wr_resp       = wr_resp_q;
  assign bus.rd_resp_valid = rd_resp_valid_q;
  assign bus.rd_resp       = rd_resp_q;
  assign bus.rd_data       = rd_data_q;

  assign wr_fire = bus.wr_valid && !wr_resp_valid_q;
  assign rd_fire = bus.rd_valid && !rd_resp_valid_q;
  assign wr_idx  = bus.wr_addr[ADDR_WIDTH-1:2];
  assign rd_idx  = bus.rd_addr[ADDR_WIDTH-1:2];

  // One-hot decode keeps out-of-range indices from ever addressing the arrays.
  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    for (int i = 0; i < int'(REG_NUM); i++) begin
      wr_hit[i] = (wr_idx == IdxW'(i));
      rd_hit[i] = (rd_idx == IdxW'(i));
    end
    wr_err   = (wr_hit == '0) || (bus.wr_addr[1:0] != 2'b00) || ((wr_hit & RO_MASK) != '0);
    rd_err   = (rd_hit == '0) || (bus.rd_addr[1:0] != 2'b00);
    wr_apply = wr_fire && !wr_err;
  end

  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < int'(StrbW); b++) begin
      wr_mask[b*8 +: 8] = {8{bus.wr_strb[b]}};
    end
  end

  // Hardware set is OR-ed in after the clear so it wins a same-cycle collision.
  always_comb begin
    for (int i = 0; i < int'(REG_NUM); i++) begin
      regs_d[i] = regs_q[i];
      if (RO_MASK[i]) begin
        regs_d[i] = '0;
      end else if (W1C_MASK[i]) begin
        if (wr_apply && wr_hit[i]) begin
          regs_d[i] = regs_q[i] & ~(bus.wr_data & wr_mask);
        end
        regs_d[i] = regs_d[i] | hw_set[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (wr_apply && wr_hit[i]) begin
        regs_d[i] = (regs_q[i] & ~wr_mask) | (bus.wr_data & wr_mask);
      end
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < int'(REG_NUM); i++) begin
      if (rd_hit[i]) begin
        rd_sel = RO_MASK[i] ? ro_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      end
    end
  end

  always_comb begin
    wr_resp_valid_d = wr_resp_valid_q;
    wr_resp_d       = wr_resp_q;
    if (wr_fire) begin
      wr_resp_valid_d = 1'b1;
      wr_resp_d       = wr_err ? RespSlverr : RespOkay;
    end else if (wr_resp_valid_q && bus.wr_resp_ready) begin
      wr_resp_valid_d = 1'b0;
    end
  end

  // Read data comes from regs_q, so a same-cycle write is not yet visible.
  always_comb begin
    rd_resp_valid_d = rd_resp_valid_q;
    rd_resp_d       = rd_resp_q;
    rd_data_d       = rd_data_q;
    if (rd_fire) begin
      rd_resp_valid_d = 1'b1;
      rd_resp_d       = rd_err ? RespSlverr : RespOkay;
      rd_data_d       = rd_err ? '0 : rd_sel;
    end else if (rd_resp_valid_q && bus.rd_resp_ready) begin
      rd_resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(REG_NUM); i++) begin
        regs_q[i] <= '0;
      end
      wr_resp_valid_q <= 1'b0;
      wr_resp_q       <= RespOkay;
      rd_resp_valid_q <= 1'b0;
      rd_resp_q       <= RespOkay;
      rd_data_q       <= '0;
    end else begin
      for (int i = 0; i < int'(REG_NUM); i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr_resp_valid_q <= wr_resp_valid_d;
      wr_resp_q       <= wr_resp_d;
      rd_resp_valid_q <= rd_resp_valid_d;
      rd_resp_q       <= rd_resp_d;
      rd_data_q       <= rd_data_d;
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < int'(REG_NUM); i++) begin
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

endmodule
